// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand buffer: FSM encoding and sizing helper.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD_IN = 2'd0,
        LOAD_F  = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } conv_state_e;

    // Ceiling log2, never below 1 so the result can always size a vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/conv_operand_buffer_if.sv
// Load and window channels of the operand buffer. The master side is the buffer itself:
// it accepts load words and sources windows. The slave side is the surrounding system.
interface conv_operand_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K_N    = 9,
    parameter int unsigned POS_W  = 1
) ();

    logic                    load_valid;
    logic                    load_ready;
    logic [DATA_W-1:0]       load_data;
    logic                    win_valid;
    logic                    win_ready;
    logic [K_N*DATA_W-1:0]   win_data;
    logic [POS_W-1:0]        win_row;
    logic [POS_W-1:0]        win_col;
    logic                    win_last;

    modport master (
        input  load_valid, load_data, win_ready,
        output load_ready, win_valid, win_data, win_row, win_col, win_last
    );

    modport slave (
        output load_valid, load_data, win_ready,
        input  load_ready, win_valid, win_data, win_row, win_col, win_last
    );

endinterface

// File: rtl/conv_window_select.sv
// Combinational extraction of the K_DIM x K_DIM window whose top-left corner is (row, col).
module conv_window_select #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 4,
    parameter int unsigned K_DIM  = 3,
    parameter int unsigned POS_W  = 1
) (
    input  logic [IN_DIM*IN_DIM*DATA_W-1:0] input_flat,
    input  logic [POS_W-1:0]                row,
    input  logic [POS_W-1:0]                col,
    output logic [K_DIM*K_DIM*DATA_W-1:0]   win_data
);

    // Gather window element r*K_DIM+c from input element (row+r)*IN_DIM + col+c.
    always_comb begin
        win_data = '0;
        for (int r = 0; r < int'(K_DIM); r++) begin
            for (int c = 0; c < int'(K_DIM); c++) begin
                win_data[(r*int'(K_DIM)+c)*int'(DATA_W) +: DATA_W] =
                    input_flat[((int'(row)+r)*int'(IN_DIM) + int'(col)+c)*int'(DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/conv_operand_buffer.sv
// Operand buffer for a small convolution: loads an input map then a filter, then streams
// every valid filter-sized window of the input map in row-major order.
module conv_operand_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 4,
    parameter int unsigned K_DIM  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              replay,
    output logic                              loaded,
    output logic [IN_DIM*IN_DIM*DATA_W-1:0]   input_flat,
    output logic [K_DIM*K_DIM*DATA_W-1:0]     filter_flat,
    conv_operand_buffer_if.master             bus
);

    localparam int unsigned OUT_DIM = IN_DIM - K_DIM + 1;
    localparam int unsigned IN_N    = IN_DIM * IN_DIM;
    localparam int unsigned K_N     = K_DIM * K_DIM;
    localparam int unsigned POS_W   = clog2(OUT_DIM);
    localparam int unsigned CNT_W   = clog2(IN_N);

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_N - 1);
    localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(K_N - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_DIM - 1);

    conv_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [POS_W-1:0]  row_q;
    logic [POS_W-1:0]  col_q;
    logic              loaded_q;
    logic              win_valid_q;
    logic              load_ready_q;

    logic [DATA_W-1:0] in_mem [IN_N];
    logic [DATA_W-1:0] f_mem  [K_N];

    logic load_xfer;
    logic win_xfer;
    logic at_last;

    // Ready is gated by reset so nothing is accepted while rst is held.
    assign bus.load_ready = load_ready_q & ~rst;
    assign load_xfer      = bus.load_valid & bus.load_ready;
    assign win_xfer       = win_valid_q & bus.win_ready;
    assign at_last        = (row_q == POS_LAST) && (col_q == POS_LAST);

    assign loaded        = loaded_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = row_q;
    assign bus.win_col   = col_q;
    assign bus.win_last  = win_valid_q & at_last;

    // Sequencer: load counter, window position and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD_IN;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            loaded_q     <= 1'b0;
            win_valid_q  <= 1'b0;
            load_ready_q <= 1'b1;
        end else if (clear) begin
            // Clear beats any same-cycle transfer, accept or replay.
            state_q      <= LOAD_IN;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            loaded_q     <= 1'b0;
            win_valid_q  <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                LOAD_IN: begin
                    if (load_xfer) begin
                        if (cnt_q == IN_LAST) begin
                            state_q <= LOAD_F;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_F: begin
                    if (load_xfer) begin
                        if (cnt_q == F_LAST) begin
                            state_q      <= STREAM;
                            cnt_q        <= '0;
                            loaded_q     <= 1'b1;
                            win_valid_q  <= 1'b1;
                            load_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (win_xfer) begin
                        if (at_last) begin
                            state_q     <= DONE;
                            row_q       <= '0;
                            col_q       <= '0;
                            win_valid_q <= 1'b0;
                        end else if (col_q == POS_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (replay) begin
                        state_q     <= STREAM;
                        win_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= LOAD_IN;
                end
            endcase
        end
    end

    // Operand storage; contents survive clear and are only zeroed by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(IN_N); i++) begin
                in_mem[i] <= '0;
            end
            for (int i = 0; i < int'(K_N); i++) begin
                f_mem[i] <= '0;
            end
        end else if (!clear && load_xfer) begin
            if (state_q == LOAD_IN) begin
                in_mem[cnt_q] <= bus.load_data;
            end else if (state_q == LOAD_F) begin
                f_mem[cnt_q] <= bus.load_data;
            end
        end
    end

    // Flatten storage onto the exported operand buses.
    always_comb begin
        input_flat  = '0;
        filter_flat = '0;
        for (int i = 0; i < int'(IN_N); i++) begin
            input_flat[i*int'(DATA_W) +: DATA_W] = in_mem[i];
        end
        for (int i = 0; i < int'(K_N); i++) begin
            filter_flat[i*int'(DATA_W) +: DATA_W] = f_mem[i];
        end
    end

    conv_window_select #(
        .DATA_W (DATA_W),
        .IN_DIM (IN_DIM),
        .K_DIM  (K_DIM),
        .POS_W  (POS_W)
    ) u_window_select (
        .input_flat (input_flat),
        .row        (row_q),
        .col        (col_q),
        .win_data   (bus.win_data)
    );

endmodule

// File: tb/tb_conv_operand_buffer.sv
// Directed and randomized checks of conv_operand_buffer at default parameters.
module tb_conv_operand_buffer;

    localparam int DW  = 8;
    localparam int ID  = 4;
    localparam int KD  = 3;
    localparam int OD  = ID - KD + 1;
    localparam int INN = ID * ID;
    localparam int KN  = KD * KD;

    logic clk;
    logic rst;
    logic clear;
    logic replay;
    logic loaded;
    logic [INN*DW-1:0] input_flat;
    logic [KN*DW-1:0]  filter_flat;

    conv_operand_buffer_if #(.DATA_W(DW), .K_N(KN), .POS_W(1)) bus ();

    conv_operand_buffer #(.DATA_W(DW), .IN_DIM(ID), .K_DIM(KD)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .replay      (replay),
        .loaded      (loaded),
        .input_flat  (input_flat),
        .filter_flat (filter_flat),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] in_ref [INN];
    logic [DW-1:0] f_ref  [KN];

    int init_in [INN] = '{112, 224, 174, 135, 41, 225, 115, 246,
                          49, 73, 215, 106, 59, 227, 21, 64};
    int init_f  [KN]  = '{70, 87, 210, 89, 191, 144, 184, 113, 177};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        step();
        bus.load_valid = 1'b0;
    endtask

    function automatic logic [KN*DW-1:0] ref_win(input int r, input int c);
        logic [KN*DW-1:0] w;
        w = '0;
        for (int i = 0; i < KD; i++)
            for (int j = 0; j < KD; j++)
                w[(i*KD+j)*DW +: DW] = in_ref[(r+i)*ID + c + j];
        return w;
    endfunction

    function automatic logic [INN*DW-1:0] ref_in_flat();
        logic [INN*DW-1:0] v;
        for (int i = 0; i < INN; i++) v[i*DW +: DW] = in_ref[i];
        return v;
    endfunction

    function automatic logic [KN*DW-1:0] ref_f_flat();
        logic [KN*DW-1:0] v;
        for (int i = 0; i < KN; i++) v[i*DW +: DW] = f_ref[i];
        return v;
    endfunction

    task automatic check_window(input string tag, input int r, input int c);
        check({tag, "_valid"}, bus.win_valid, 1);
        check({tag, "_row"}, bus.win_row, r);
        check({tag, "_col"}, bus.win_col, c);
        check({tag, "_data"}, bus.win_data, ref_win(r, c));
        check({tag, "_last"}, bus.win_last, (r == OD-1 && c == OD-1) ? 1 : 0);
    endtask

    initial begin
        int pos;
        int cyc;
        logic rdy;

        rst = 1'b1; clear = 1'b0; replay = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.win_ready = 1'b0;
        for (int i = 0; i < INN; i++) in_ref[i] = '0;
        for (int i = 0; i < KN; i++) f_ref[i] = '0;

        // Reset state, and no transfer accepted while rst is held.
        repeat (2) step();
        bus.load_valid = 1'b1; bus.load_data = 8'hA5;
        step();
        bus.load_valid = 1'b0;
        check("rst_loaded", loaded, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_last", bus.win_last, 0);
        check("rst_row", bus.win_row, 0);
        check("rst_col", bus.win_col, 0);
        check("rst_input_flat", input_flat, 0);
        check("rst_filter_flat", filter_flat, 0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", bus.load_ready, 1);

        // Directed load of the reference map and filter.
        for (int i = 0; i < INN; i++) begin
            load_word(DW'(init_in[i]));
            in_ref[i] = DW'(init_in[i]);
        end
        for (int i = 0; i < KN; i++) begin
            if (i == KN-1) check("loaded_before_last", loaded, 0);
            load_word(DW'(init_f[i]));
            f_ref[i] = DW'(init_f[i]);
        end
        check("loaded_after_last", loaded, 1);
        check("ready_in_stream", bus.load_ready, 0);
        check("input_elem0", input_flat[7:0], 112);
        check("filter_elem8", filter_flat[71:64], 177);
        check("input_flat", input_flat, ref_in_flat());
        check("filter_flat", filter_flat, ref_f_flat());

        // Full-rate stream of all four windows.
        bus.win_ready = 1'b1;
        for (int p = 0; p < OD*OD; p++) begin
            check_window("dir", p / OD, p % OD);
            if (p == 0) check("win00_literal", bus.win_data, 72'hd7_49_31_73_e1_29_ae_e0_70);
            if (p == 3) check("win11_literal", bus.win_data, 72'h40_15_e3_6a_d7_49_f6_73_e1);
            step();
        end
        check("done_valid", bus.win_valid, 0);
        check("done_loaded", loaded, 1);

        // Replay, then stall five cycles at (0,1).
        bus.win_ready = 1'b0;
        replay = 1'b1;
        step();
        replay = 1'b0;
        check_window("replay", 0, 0);
        check("replay_loaded", loaded, 1);
        bus.win_ready = 1'b1;
        step();
        bus.win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_window("stall", 0, 1);
            step();
        end
        bus.win_ready = 1'b1;
        step();
        check_window("after_stall", 1, 0);
        step();
        step();
        check("replay_done_valid", bus.win_valid, 0);

        // Clear from DONE, random reload, clear mid filter load.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_loaded", loaded, 0);
        check("clear_ready", bus.load_ready, 1);
        check("clear_valid", bus.win_valid, 0);
        check("clear_keeps_input", input_flat, ref_in_flat());
        for (int i = 0; i < INN; i++) begin
            in_ref[i] = DW'($urandom);
            load_word(in_ref[i]);
        end
        for (int i = 0; i < 4; i++) begin
            f_ref[i] = DW'($urandom);
            load_word(f_ref[i]);
        end
        bus.load_valid = 1'b1;
        bus.load_data  = DW'($urandom) ^ 8'h5a;
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.load_valid = 1'b0;
        check("clear_f_loaded", loaded, 0);
        check("clear_f_ready", bus.load_ready, 1);
        check("clear_f_word_dropped", filter_flat, ref_f_flat());

        for (int i = 0; i < INN; i++) begin
            in_ref[i] = DW'($urandom);
            load_word(in_ref[i]);
        end
        check("reload_input_flat", input_flat, ref_in_flat());
        check("reload_not_loaded", loaded, 0);
        for (int i = 0; i < KN; i++) begin
            f_ref[i] = DW'($urandom);
            load_word(f_ref[i]);
        end
        check("reload_filter_flat", filter_flat, ref_f_flat());
        check("reload_loaded", loaded, 1);

        // Random backpressure stream against the model position.
        pos = 0;
        cyc = 0;
        while (pos < OD*OD && cyc < 200) begin
            check_window("rnd", pos / OD, pos % OD);
            rdy = 1'($urandom_range(0, 1));
            bus.win_ready = rdy;
            step();
            if (rdy) pos++;
            cyc++;
        end
        check("rnd_all_accepted", pos, OD*OD);
        check("rnd_done_valid", bus.win_valid, 0);

        // Reset in the middle of a stream at (1,0).
        bus.win_ready = 1'b0;
        replay = 1'b1;
        step();
        replay = 1'b0;
        bus.win_ready = 1'b1;
        step();
        step();
        bus.win_ready = 1'b0;
        check_window("pre_rst", 1, 0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < INN; i++) in_ref[i] = '0;
        for (int i = 0; i < KN; i++) f_ref[i] = '0;
        check("midrst_valid", bus.win_valid, 0);
        check("midrst_loaded", loaded, 0);
        check("midrst_input_flat", input_flat, 0);
        check("midrst_filter_flat", filter_flat, 0);
        check("midrst_row", bus.win_row, 0);
        check("midrst_col", bus.win_col, 0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_release_ready", bus.load_ready, 1);
        in_ref[0] = 8'h3c;
        load_word(8'h3c);
        check("midrst_reload_idx0", input_flat, ref_in_flat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_operand_buffer.md
CONV_OPERAND_BUFFER -- requirements
Module: conv_operand_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one stored element.
REQ-002 SHALL have parameter IN_DIM, default 4, side of the square input map.
REQ-003 SHALL have parameter K_DIM, default 3, side of the square filter; legal range 1..IN_DIM.
REQ-004 SHALL derive OUT_DIM = IN_DIM-K_DIM+1 and IN_N = IN_DIM*IN_DIM, K_N = K_DIM*K_DIM as local constants.
REQ-005 SHALL have ports as follows:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  reset, asynchronous, active-high
  clear  input  1  synchronous restart of loading
  load_valid  input  1  load word present
  load_ready  output  1  block accepts load word
  load_data  input  DATA_W  load word; input map row-major, then filter row-major
  replay  input  1  restart window stream without reloading
  loaded  output  1  input map and filter fully stored
  input_flat  output  IN_N*DATA_W  element i at [i*DATA_W +: DATA_W]
  filter_flat  output  K_N*DATA_W  element i at [i*DATA_W +: DATA_W]
  win_valid  output  1  window present
  win_ready  input  1  consumer accepts window
  win_data  output  K_N*DATA_W  window element r*K_DIM+c = input[(row+r)*IN_DIM+col+c]
  win_row  output  clog2(OUT_DIM)  window top-left row (min width 1)
  win_col  output  clog2(OUT_DIM)  window top-left column (min width 1)
  win_last  output  1  current window is (OUT_DIM-1, OUT_DIM-1)

Function
REQ-006 SHALL implement states LOAD_IN, LOAD_F, STREAM, DONE.
REQ-007 SHALL assert load_ready only in LOAD_IN and LOAD_F; a load transfer is load_valid & load_ready in one cycle.
REQ-008 SHALL write each transferred word into the next input slot (LOAD_IN) or filter slot (LOAD_F), index counter starting at 0.
REQ-009 SHALL move LOAD_IN->LOAD_F on transfer of input word IN_N-1, and LOAD_F->STREAM on transfer of filter word K_N-1, with counter reset to 0 at each move.
REQ-010 SHALL drive loaded = 1 in STREAM and DONE, 0 otherwise.
REQ-011 SHALL hold win_valid = 1 in STREAM only; win_data, win_row, win_col, win_last SHALL remain stable while win_valid & !win_ready.
REQ-012 SHALL present windows in row-major position order, (0,0) first on the first STREAM cycle.
REQ-013 SHALL advance position on win_valid & win_ready: col+1, wrap col to 0 and row+1 at col = OUT_DIM-1.
REQ-014 SHALL move STREAM->DONE when the win_last window is accepted; position returns to (0,0).
REQ-015 SHALL, in DONE, on replay = 1, enter STREAM at (0,0) with stored data unchanged; replay SHALL be ignored in other states.
REQ-016 SHALL, on clear = 1 in any state, enter LOAD_IN next cycle with counters and position 0 and loaded = 0; clear SHALL take priority over a same-cycle load transfer, window accept or replay, and that transfer SHALL NOT be stored or counted.
REQ-017 SHALL retain stored input and filter contents across clear until overwritten by new loads.
REQ-018 SHALL drive input_flat and filter_flat directly from storage at all times, updating the cycle after each write.
REQ-019 SHALL, for OUT_DIM = 1, assert win_last on the only window.

Reset
REQ-020 SHALL on rst = 1, asynchronously: state LOAD_IN, all counters and position 0, all storage 0.
REQ-021 SHALL, during and after reset, drive loaded 0, win_valid 0, win_last 0, win_row/win_col 0, load_ready 1 (once rst deasserts), input_flat and filter_flat all zero.
REQ-022 SHALL discard any partial load or stream on rst mid-operation; no transfer SHALL be accepted while rst = 1.

Structure
REQ-023 SHALL place the state encoding and the clog2 helper in shared package conv_pkg.
REQ-024 SHALL contain one sub-module, conv_window_select, combinational extraction of the K_DIM x K_DIM window from input storage given (row, col).

Verification
REQ-025 Defaults, load 112,224,174,135,41,225,115,246,49,73,215,106,59,227,21,64, then 70,87,210,89,191,144,184,113,177 -> loaded = 1 one cycle after last transfer; input_flat[7:0] = 112, filter_flat[71:64] = 177.
REQ-026 After REQ-025, win_ready = 1 -> windows (0,0),(0,1),(1,0),(1,1) on 4 consecutive cycles; (0,0) = 112,224,174,41,225,115,49,73,215; (1,1) = 225,115,246,73,215,106,227,21,64 with win_last = 1; then win_valid = 0.
REQ-027 Stream with win_ready held 0 for 5 cycles at (0,1) -> win_data/win_col stable for all 5 cycles; advance only when win_ready = 1.
REQ-028 In DONE, pulse replay -> window (0,0) reappears with identical data; loaded stays 1.
REQ-029 In LOAD_F after 4 filter words, assert clear with load_valid = 1 -> state LOAD_IN, loaded = 0, that word not stored; next 16 words refill the input map from index 0.
REQ-030 Assert rst mid-stream at (1,0) -> same cycle win_valid = 0, loaded = 0, input_flat all zero; after release, load_ready = 1.
